// File: rtl/pipe_share_arbiter.sv
// Round-robin sharing of one fixed-latency, non-stallable pipeline with credit-based response FIFO.
// Define PIPE_SHARE_ARBITER_PERF_EN to add issue/stall counters and a FIFO overflow assertion.
module pipe_share_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_W       = 32,
    parameter int PIPE_LATENCY = 3,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [DATA_W-1:0]          pipe_x,
    input  logic [DATA_W-1:0]          pipe_out,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [DATA_W-1:0]          rsp_data,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic                       busy
`ifdef PIPE_SHARE_ARBITER_PERF_EN
    ,
    output logic [31:0]                perf_issue_cnt,
    output logic [31:0]                perf_stall_cnt
`endif
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int STG   = PIPE_LATENCY + 1;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
    localparam int INF_W = $clog2(STG + 1);

    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   gnt_id;
    logic [ID_W-1:0]   cand;
    logic              gnt_found;
    logic              credit_ok;
    logic              issue;
    logic              retire;
    logic              push;
    logic              pop;
    logic [STG:1]      tok_v;
    logic [ID_W-1:0]   tok_id [1:STG];
    logic [INF_W-1:0]  inflight;
    logic [OCC_W-1:0]  occ;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
    logic [ID_W-1:0]   fifo_id   [FIFO_DEPTH];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (int'(p) == FIFO_DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    // A slot is consumed from issue until the pop edge; a same-cycle pop is not reused.
    assign credit_ok = (int'(occ) + int'(inflight)) < FIFO_DEPTH;

    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_id    = cand;
            end
        end
    end

    assign issue = rst_n & gnt_found & credit_ok;

    always_comb begin
        req_ready = '0;
        if (issue) begin
            req_ready[gnt_id] = 1'b1;
        end
    end

    assign pipe_x = issue ? req_data[int'(gnt_id)*DATA_W +: DATA_W] : '0;

    // Last token stage lines up with the cycle pipe_out holds its result.
    assign retire    = tok_v[STG];
    assign push      = retire;
    assign rsp_valid = (occ != '0);
    assign pop       = rsp_valid & rsp_ready;
    assign rsp_data  = rsp_valid ? fifo_data[rd_ptr] : '0;
    assign rsp_id    = rsp_valid ? fifo_id[rd_ptr] : '0;
    assign busy      = rsp_valid | (inflight != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr   <= ID_W'(NUM_REQ - 1);
            tok_v    <= '0;
            inflight <= '0;
            occ      <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            if (issue) begin
                rr_ptr <= gnt_id;
            end
            tok_v[1] <= issue;
            for (int i = 2; i <= STG; i++) begin
                tok_v[i] <= tok_v[i-1];
            end
            inflight <= inflight + INF_W'(issue) - INF_W'(retire);
            occ      <= occ + OCC_W'(push) - OCC_W'(pop);
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
        end
    end

    always_ff @(posedge clk) begin
        tok_id[1] <= gnt_id;
        for (int i = 2; i <= STG; i++) begin
            tok_id[i] <= tok_id[i-1];
        end
        if (push) begin
            fifo_data[wr_ptr] <= pipe_out;
            fifo_id[wr_ptr]   <= tok_id[STG];
        end
    end

`ifdef PIPE_SHARE_ARBITER_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_issue_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (issue && perf_issue_cnt != '1) begin
                perf_issue_cnt <= perf_issue_cnt + 32'd1;
            end
            if (|req_valid && !credit_ok && perf_stall_cnt != '1) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(push && occ == OCC_W'(FIFO_DEPTH)));
        end
    end
`endif

endmodule
